// File: rtl/fpu_req_issuer_if.sv
// Handshake/bus bundle between the FPU request issuer and its neighbours:
// issue stage commands, FPU request/response, writeback, and status.
interface fpu_req_issuer_if #(
    parameter int WIDTH      = 512,
    parameter int TAG_WIDTH  = 3,
    parameter int META_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [WIDTH-1:0]      cmd_bits_operands_0;
    logic [WIDTH-1:0]      cmd_bits_operands_1;
    logic [WIDTH-1:0]      cmd_bits_operands_2;
    logic [4:0]            cmd_bits_op;
    logic [2:0]            cmd_bits_roundingMode;
    logic [2:0]            cmd_bits_srcFormat;
    logic [2:0]            cmd_bits_dstFormat;
    logic [1:0]            cmd_bits_intFormat;
    logic [15:0]           cmd_bits_simdMask;
    logic [META_WIDTH-1:0] cmd_bits_meta;

    logic                  fpu_req_valid;
    logic                  fpu_req_ready;
    logic [WIDTH-1:0]      fpu_req_bits_operands_0;
    logic [WIDTH-1:0]      fpu_req_bits_operands_1;
    logic [WIDTH-1:0]      fpu_req_bits_operands_2;
    logic [4:0]            fpu_req_bits_op;
    logic [2:0]            fpu_req_bits_roundingMode;
    logic [2:0]            fpu_req_bits_srcFormat;
    logic [2:0]            fpu_req_bits_dstFormat;
    logic [1:0]            fpu_req_bits_intFormat;
    logic [15:0]           fpu_req_bits_simdMask;
    logic [TAG_WIDTH-1:0]  fpu_req_bits_tag;

    logic                  fpu_resp_valid;
    logic                  fpu_resp_ready;
    logic [WIDTH-1:0]      fpu_resp_bits_result;
    logic [4:0]            fpu_resp_bits_status;
    logic [TAG_WIDTH-1:0]  fpu_resp_bits_tag;

    logic                  fpu_flush;
    logic                  abort;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [WIDTH-1:0]      wb_bits_result;
    logic [4:0]            wb_bits_status;
    logic [META_WIDTH-1:0] wb_bits_meta;

    logic [TAG_WIDTH:0]    inflight_count;
    logic                  spurious_err;
    logic                  busy;
    logic [4:0]            fflags;
    logic                  fflags_clear;

    // master: the issuer itself
    modport master (
        input  cmd_valid, cmd_bits_operands_0, cmd_bits_operands_1, cmd_bits_operands_2,
               cmd_bits_op, cmd_bits_roundingMode, cmd_bits_srcFormat, cmd_bits_dstFormat,
               cmd_bits_intFormat, cmd_bits_simdMask, cmd_bits_meta,
               fpu_req_ready, fpu_resp_valid, fpu_resp_bits_result, fpu_resp_bits_status,
               fpu_resp_bits_tag, abort, wb_ready, fflags_clear,
        output cmd_ready, fpu_req_valid, fpu_req_bits_operands_0, fpu_req_bits_operands_1,
               fpu_req_bits_operands_2, fpu_req_bits_op, fpu_req_bits_roundingMode,
               fpu_req_bits_srcFormat, fpu_req_bits_dstFormat, fpu_req_bits_intFormat,
               fpu_req_bits_simdMask, fpu_req_bits_tag, fpu_resp_ready, fpu_flush,
               wb_valid, wb_bits_result, wb_bits_status, wb_bits_meta,
               inflight_count, spurious_err, busy, fflags
    );

    modport slave (
        output cmd_valid, cmd_bits_operands_0, cmd_bits_operands_1, cmd_bits_operands_2,
               cmd_bits_op, cmd_bits_roundingMode, cmd_bits_srcFormat, cmd_bits_dstFormat,
               cmd_bits_intFormat, cmd_bits_simdMask, cmd_bits_meta,
               fpu_req_ready, fpu_resp_valid, fpu_resp_bits_result, fpu_resp_bits_status,
               fpu_resp_bits_tag, abort, wb_ready, fflags_clear,
        input  cmd_ready, fpu_req_valid, fpu_req_bits_operands_0, fpu_req_bits_operands_1,
               fpu_req_bits_operands_2, fpu_req_bits_op, fpu_req_bits_roundingMode,
               fpu_req_bits_srcFormat, fpu_req_bits_dstFormat, fpu_req_bits_intFormat,
               fpu_req_bits_simdMask, fpu_req_bits_tag, fpu_resp_ready, fpu_flush,
               wb_valid, wb_bits_result, wb_bits_status, wb_bits_meta,
               inflight_count, spurious_err, busy, fflags
    );
endinterface

// File: rtl/fpu_req_issuer.sv
// Tag-allocating FPU request issuer: one request register, one writeback register,
// per-tag metadata table. Optional fflags accumulator under FPU_ISSUER_FFLAGS_EN.
module fpu_req_issuer #(
    parameter int WIDTH      = 512,
    parameter int TAG_WIDTH  = 3,
    parameter int META_WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    fpu_req_issuer_if.master bus
);
    localparam int NUM_TAGS = 1 << TAG_WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0]     op0;
        logic [WIDTH-1:0]     op1;
        logic [WIDTH-1:0]     op2;
        logic [4:0]           op;
        logic [2:0]           rm;
        logic [2:0]           src_fmt;
        logic [2:0]           dst_fmt;
        logic [1:0]           int_fmt;
        logic [15:0]          mask;
        logic [TAG_WIDTH-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0]      result;
        logic [4:0]            status;
        logic [META_WIDTH-1:0] meta;
    } wb_t;

    logic [NUM_TAGS-1:0]   alloc;
    logic [META_WIDTH-1:0] meta_tbl [NUM_TAGS];
    req_t                  req_q;
    logic                  req_vld;
    wb_t                   wb_q;
    logic                  wb_vld;
    logic [TAG_WIDTH:0]    inflight;
    logic                  spurious;

    logic [TAG_WIDTH-1:0]  free_tag;
    logic                  has_free;
    logic                  cmd_fire, resp_fire, resp_hit;
    logic [NUM_TAGS-1:0]   set_mask, clr_mask;

    // descending scan so the lowest free index wins
    always_comb begin
        free_tag = '0;
        has_free = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!alloc[i]) begin
                free_tag = TAG_WIDTH'(i);
                has_free = 1'b1;
            end
        end
    end

    assign bus.cmd_ready      = reset && !bus.abort && has_free && (!req_vld || bus.fpu_req_ready);
    assign bus.fpu_resp_ready = reset && !bus.abort && (!wb_vld || bus.wb_ready);
    assign bus.fpu_flush      = reset && bus.abort;

    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign resp_fire = bus.fpu_resp_valid && bus.fpu_resp_ready;
    assign resp_hit  = resp_fire && alloc[bus.fpu_resp_bits_tag];
    assign set_mask  = cmd_fire ? (NUM_TAGS'(1) << free_tag) : '0;
    assign clr_mask  = resp_hit ? (NUM_TAGS'(1) << bus.fpu_resp_bits_tag) : '0;

    // a freed tag cannot be reallocated in the same cycle: free_tag comes from registered alloc
    always_ff @(posedge clock) begin
        if (!reset) begin
            alloc    <= '0;
            req_vld  <= 1'b0;
            wb_vld   <= 1'b0;
            inflight <= '0;
            spurious <= 1'b0;
        end else if (bus.abort) begin
            alloc    <= '0;
            req_vld  <= 1'b0;
            wb_vld   <= 1'b0;
            inflight <= '0;
        end else begin
            if (cmd_fire)               req_vld <= 1'b1;
            else if (bus.fpu_req_ready) req_vld <= 1'b0;
            if (resp_hit)               wb_vld <= 1'b1;
            else if (bus.wb_ready)      wb_vld <= 1'b0;
            alloc    <= (alloc | set_mask) & ~clr_mask;
            inflight <= inflight + (TAG_WIDTH+1)'(cmd_fire) - (TAG_WIDTH+1)'(resp_hit);
            if (resp_fire && !resp_hit) spurious <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (cmd_fire) begin
            req_q <= '{op0: bus.cmd_bits_operands_0, op1: bus.cmd_bits_operands_1,
                       op2: bus.cmd_bits_operands_2, op: bus.cmd_bits_op,
                       rm: bus.cmd_bits_roundingMode, src_fmt: bus.cmd_bits_srcFormat,
                       dst_fmt: bus.cmd_bits_dstFormat, int_fmt: bus.cmd_bits_intFormat,
                       mask: bus.cmd_bits_simdMask, tag: free_tag};
            meta_tbl[free_tag] <= bus.cmd_bits_meta;
        end
        if (resp_hit)
            wb_q <= '{result: bus.fpu_resp_bits_result, status: bus.fpu_resp_bits_status,
                      meta: meta_tbl[bus.fpu_resp_bits_tag]};
    end

    assign bus.fpu_req_valid             = req_vld;
    assign bus.fpu_req_bits_operands_0   = req_q.op0;
    assign bus.fpu_req_bits_operands_1   = req_q.op1;
    assign bus.fpu_req_bits_operands_2   = req_q.op2;
    assign bus.fpu_req_bits_op           = req_q.op;
    assign bus.fpu_req_bits_roundingMode = req_q.rm;
    assign bus.fpu_req_bits_srcFormat    = req_q.src_fmt;
    assign bus.fpu_req_bits_dstFormat    = req_q.dst_fmt;
    assign bus.fpu_req_bits_intFormat    = req_q.int_fmt;
    assign bus.fpu_req_bits_simdMask     = req_q.mask;
    assign bus.fpu_req_bits_tag          = req_q.tag;

    assign bus.wb_valid       = wb_vld;
    assign bus.wb_bits_result = wb_q.result;
    assign bus.wb_bits_status = wb_q.status;
    assign bus.wb_bits_meta   = wb_q.meta;

    assign bus.inflight_count = inflight;
    assign bus.spurious_err   = spurious;
    assign bus.busy           = (|alloc) || req_vld || wb_vld;

`ifdef FPU_ISSUER_FFLAGS_EN
    logic [4:0] fflags_q;
    // clear has priority over a same-cycle writeback OR
    always_ff @(posedge clock) begin
        if (!reset)                  fflags_q <= '0;
        else if (bus.fflags_clear)   fflags_q <= '0;
        else if (wb_vld && bus.wb_ready) fflags_q <= fflags_q | wb_q.status;
    end
    assign bus.fflags = fflags_q;
`else
    logic unused_fflags_clear;
    assign unused_fflags_clear = bus.fflags_clear;
    assign bus.fflags          = 5'd0;
`endif
endmodule

// File: tb/tb_fpu_req_issuer.sv
// Bench for fpu_req_issuer: directed scenarios plus a random phase, every cycle
// checked against a queue/associative-array model of tag lifetime.
module tb_fpu_req_issuer;
    localparam int WIDTH = 512;
    localparam int TW    = 3;
    localparam int MW    = 10;
    localparam int NT    = 8;

    typedef logic [WIDTH-1:0] w_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_req_issuer_if #(.WIDTH(WIDTH), .TAG_WIDTH(TW), .META_WIDTH(MW)) bus ();

    fpu_req_issuer #(.WIDTH(WIDTH), .TAG_WIDTH(TW), .META_WIDTH(MW)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        int          tag;
        w_t          op0;
        logic [4:0]  op;
        logic [15:0] mask;
    } req_m_t;

    typedef struct {
        w_t          result;
        logic [4:0]  status;
        logic [MW-1:0] meta;
    } wb_m_t;

    // model: live tags with their metadata, pending request / writeback
    logic [MW-1:0] live [int];
    req_m_t        req_m[$];
    wb_m_t         wb_m[$];
    bit            spur_m = 1'b0;
    logic [4:0]    ff_m = '0;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  cmd_fired, resp_fired;
    int  last_tag;
    int  keys[$];

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.cmd_valid             = 1'b0;
        bus.cmd_bits_operands_0   = '0;
        bus.cmd_bits_operands_1   = '0;
        bus.cmd_bits_operands_2   = '0;
        bus.cmd_bits_op           = '0;
        bus.cmd_bits_roundingMode = '0;
        bus.cmd_bits_srcFormat    = '0;
        bus.cmd_bits_dstFormat    = '0;
        bus.cmd_bits_intFormat    = '0;
        bus.cmd_bits_simdMask     = '0;
        bus.cmd_bits_meta         = '0;
        bus.fpu_req_ready         = 1'b1;
        bus.fpu_resp_valid        = 1'b0;
        bus.fpu_resp_bits_result  = '0;
        bus.fpu_resp_bits_status  = '0;
        bus.fpu_resp_bits_tag     = '0;
        bus.abort                 = 1'b0;
        bus.wb_ready              = 1'b1;
        bus.fflags_clear          = 1'b0;
    endtask

    task automatic set_cmd(input logic [MW-1:0] meta);
        bus.cmd_bits_operands_0   = {$urandom(), $urandom(), $urandom(), $urandom(),
                                     $urandom(), $urandom(), $urandom(), $urandom(),
                                     $urandom(), $urandom(), $urandom(), $urandom(),
                                     $urandom(), $urandom(), $urandom(), $urandom()};
        bus.cmd_bits_operands_1   = {16{$urandom()}};
        bus.cmd_bits_operands_2   = {16{$urandom()}};
        bus.cmd_bits_op           = 5'($urandom());
        bus.cmd_bits_roundingMode = 3'($urandom());
        bus.cmd_bits_srcFormat    = 3'($urandom());
        bus.cmd_bits_dstFormat    = 3'($urandom());
        bus.cmd_bits_intFormat    = 2'($urandom());
        bus.cmd_bits_simdMask     = 16'($urandom());
        bus.cmd_bits_meta         = meta;
    endtask

    // One clock: check every output against the model, then advance the model
    // by the rules of tag allocation/free, abort and reset.
    task automatic tick();
        int     free_t;
        bit     cr, rr, cf, rf, hit;
        req_m_t rq;
        wb_m_t  wq;
        int     rtag;
        #1;
        free_t = -1;
        for (int i = NT - 1; i >= 0; i--) if (!live.exists(i)) free_t = i;
        cr = rst_n && !bus.abort && (free_t >= 0) && (req_m.size() == 0 || bus.fpu_req_ready);
        rr = rst_n && !bus.abort && (wb_m.size() == 0 || bus.wb_ready);

        chk("cmd_ready", w_t'(bus.cmd_ready), w_t'(cr));
        chk("fpu_resp_ready", w_t'(bus.fpu_resp_ready), w_t'(rr));
        chk("fpu_flush", w_t'(bus.fpu_flush), w_t'(rst_n && bus.abort));
        chk("fpu_req_valid", w_t'(bus.fpu_req_valid), w_t'(req_m.size() != 0));
        if (req_m.size() != 0) begin
            chk("fpu_req_tag", w_t'(bus.fpu_req_bits_tag), w_t'(req_m[0].tag));
            chk("fpu_req_op0", bus.fpu_req_bits_operands_0, req_m[0].op0);
            chk("fpu_req_op", w_t'(bus.fpu_req_bits_op), w_t'(req_m[0].op));
            chk("fpu_req_mask", w_t'(bus.fpu_req_bits_simdMask), w_t'(req_m[0].mask));
        end
        chk("wb_valid", w_t'(bus.wb_valid), w_t'(wb_m.size() != 0));
        if (wb_m.size() != 0) begin
            chk("wb_result", bus.wb_bits_result, wb_m[0].result);
            chk("wb_status", w_t'(bus.wb_bits_status), w_t'(wb_m[0].status));
            chk("wb_meta", w_t'(bus.wb_bits_meta), w_t'(wb_m[0].meta));
        end
        chk("inflight_count", w_t'(bus.inflight_count), w_t'(live.num()));
        chk("busy", w_t'(bus.busy), w_t'(live.num() != 0 || req_m.size() != 0 || wb_m.size() != 0));
        chk("spurious_err", w_t'(bus.spurious_err), w_t'(spur_m));
        chk("fflags", w_t'(bus.fflags), w_t'(ff_m));

        cf   = bus.cmd_valid && cr;
        rf   = bus.fpu_resp_valid && rr;
        rtag = int'(bus.fpu_resp_bits_tag);
        hit  = rf && live.exists(rtag);
        cmd_fired  = cf;
        resp_fired = rf;

        if (!rst_n) begin
            live.delete();
            req_m.delete();
            wb_m.delete();
            spur_m = 1'b0;
            ff_m   = '0;
        end else begin
`ifdef FPU_ISSUER_FFLAGS_EN
            if (bus.fflags_clear) ff_m = '0;
            else if (wb_m.size() != 0 && bus.wb_ready) ff_m = ff_m | wb_m[0].status;
`endif
            if (rf && !hit) spur_m = 1'b1;
            if (wb_m.size() != 0 && (bus.wb_ready || bus.abort)) void'(wb_m.pop_front());
            if (hit) begin
                wq.result = bus.fpu_resp_bits_result;
                wq.status = bus.fpu_resp_bits_status;
                wq.meta   = live[rtag];
                wb_m.push_back(wq);
                live.delete(rtag);
            end
            if (req_m.size() != 0 && (bus.fpu_req_ready || bus.abort)) void'(req_m.pop_front());
            if (cf) begin
                rq.tag  = free_t;
                rq.op0  = bus.cmd_bits_operands_0;
                rq.op   = bus.cmd_bits_op;
                rq.mask = bus.cmd_bits_simdMask;
                req_m.push_back(rq);
                live[free_t] = bus.cmd_bits_meta;
                last_tag = free_t;
            end
            if (bus.abort) live.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [MW-1:0] meta);
        bus.cmd_valid = 1'b1;
        set_cmd(meta);
        cmd_fired = 1'b0;
        for (int k = 0; k < 32 && !cmd_fired; k++) tick();
        bus.cmd_valid = 1'b0;
        chk("cmd_accept_timeout", w_t'(cmd_fired), w_t'(1));
    endtask

    task automatic respond(input int tag, input w_t result, input logic [4:0] status);
        bus.fpu_resp_valid       = 1'b1;
        bus.fpu_resp_bits_tag    = TW'(tag);
        bus.fpu_resp_bits_result = result;
        bus.fpu_resp_bits_status = status;
        resp_fired = 1'b0;
        for (int k = 0; k < 32 && !resp_fired; k++) tick();
        bus.fpu_resp_valid = 1'b0;
        chk("resp_accept_timeout", w_t'(resp_fired), w_t'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset: outputs low even with valid/abort asserted
        idle();
        rst_n = 1'b0;
        bus.cmd_valid      = 1'b1;
        bus.fpu_resp_valid = 1'b1;
        bus.abort          = 1'b1;
        @(posedge clk);
        #1;
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        // single op
        issue(10'h05);
        chk("single_req_valid", w_t'(bus.fpu_req_valid), w_t'(1));
        chk("single_req_tag", w_t'(bus.fpu_req_bits_tag), w_t'(0));
        chk("single_inflight1", w_t'(bus.inflight_count), w_t'(1));
        tick();
        respond(0, {128{4'hA}}, 5'h00);
        chk("single_wb_valid", w_t'(bus.wb_valid), w_t'(1));
        chk("single_wb_meta", w_t'(bus.wb_bits_meta), w_t'(10'h05));
        chk("single_inflight0", w_t'(bus.inflight_count), w_t'(0));
        tick();

        // fill all tags, then recycle tag 3
        for (int i = 0; i < NT; i++) issue(MW'(32'h20 + i));
        chk("fill_inflight", w_t'(bus.inflight_count), w_t'(8));
        bus.cmd_valid = 1'b1;
        #1;
        chk("fill_cmd_ready", w_t'(bus.cmd_ready), w_t'(0));
        respond(3, {16{$urandom()}}, 5'($urandom()));
        issue(10'h2F);
        chk("refill_tag", w_t'(bus.fpu_req_bits_tag), w_t'(3));
        for (int t = 0; t < NT; t++) respond(t, {16{$urandom()}}, 5'($urandom()));
        tick();

        // out-of-order return
        issue(10'h10);
        issue(10'h11);
        issue(10'h12);
        respond(2, {16{$urandom()}}, 5'h00);
        chk("ooo_meta_a", w_t'(bus.wb_bits_meta), w_t'(10'h12));
        respond(0, {16{$urandom()}}, 5'h00);
        chk("ooo_meta_b", w_t'(bus.wb_bits_meta), w_t'(10'h10));
        respond(1, {16{$urandom()}}, 5'h00);
        chk("ooo_meta_c", w_t'(bus.wb_bits_meta), w_t'(10'h11));
        tick();

        // writeback backpressure
        issue(10'h30);
        issue(10'h31);
        bus.wb_ready = 1'b0;
        respond(0, {16{$urandom()}}, 5'h00);
        bus.fpu_resp_valid       = 1'b1;
        bus.fpu_resp_bits_tag    = 3'd1;
        bus.fpu_resp_bits_result = {16{$urandom()}};
        #1;
        chk("bp_resp_ready", w_t'(bus.fpu_resp_ready), w_t'(0));
        chk("bp_wb_meta_held", w_t'(bus.wb_bits_meta), w_t'(10'h30));
        tick();
        tick();
        tick();
        bus.wb_ready = 1'b1;
        respond(1, {16{$urandom()}}, 5'h00);
        chk("bp_wb_meta_second", w_t'(bus.wb_bits_meta), w_t'(10'h31));
        tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            set_cmd(MW'($urandom()));
            bus.fpu_req_ready = ($urandom_range(0, 3) != 0);
            bus.wb_ready      = ($urandom_range(0, 3) != 0);
            bus.fflags_clear  = ($urandom_range(0, 15) == 0);
            bus.abort         = ($urandom_range(0, 49) == 0);
            keys.delete();
            foreach (live[t]) keys.push_back(t);
            if (keys.size() != 0 && $urandom_range(0, 1) == 1) begin
                bus.fpu_resp_valid       = 1'b1;
                bus.fpu_resp_bits_tag    = TW'(keys[$urandom_range(0, keys.size() - 1)]);
                bus.fpu_resp_bits_result = {16{$urandom()}};
                bus.fpu_resp_bits_status = 5'($urandom());
            end else begin
                bus.fpu_resp_valid = 1'b0;
            end
            tick();
        end
        idle();
        bus.abort = 1'b1;
        tick();
        idle();
        tick();

        // abort with four in flight
        for (int i = 0; i < 4; i++) issue(MW'(32'h50 + i));
        bus.abort = 1'b1;
        bus.cmd_valid = 1'b1;
        set_cmd(10'h3FF);
        bus.fpu_resp_valid    = 1'b1;
        bus.fpu_resp_bits_tag = 3'd0;
        #1;
        chk("abort_flush", w_t'(bus.fpu_flush), w_t'(1));
        chk("abort_cmd_ready", w_t'(bus.cmd_ready), w_t'(0));
        tick();
        idle();
        chk("abort_inflight", w_t'(bus.inflight_count), w_t'(0));
        chk("abort_busy", w_t'(bus.busy), w_t'(0));
        chk("abort_spur_before", w_t'(bus.spurious_err), w_t'(0));
        respond(1, {16{$urandom()}}, 5'h00);
        chk("abort_spur_after", w_t'(bus.spurious_err), w_t'(1));
        chk("abort_wb_dropped", w_t'(bus.wb_valid), w_t'(0));
        tick();

        // status accumulation
        bus.fflags_clear = 1'b1;
        tick();
        bus.fflags_clear = 1'b0;
        issue(10'h40);
        issue(10'h41);
        respond(0, {16{$urandom()}}, 5'h01);
        respond(1, {16{$urandom()}}, 5'h10);
        tick();
`ifdef FPU_ISSUER_FFLAGS_EN
        chk("fflags_or", w_t'(bus.fflags), w_t'(5'h11));
`else
        chk("fflags_off", w_t'(bus.fflags), w_t'(5'h00));
`endif
        bus.fflags_clear = 1'b1;
        tick();
        bus.fflags_clear = 1'b0;
        chk("fflags_cleared", w_t'(bus.fflags), w_t'(5'h00));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_req_issuer.md
# fpu_req_issuer

Initiator-side companion to the vector FPU wrapper. Accepts SIMD FP commands from the issue stage, allocates a tag per command, drives the FPU request handshake, and matches returning FPU responses (possibly out of order across units) back to per-tag metadata for register writeback. Sits between the warp issue/operand collector and the FPU, owning tag lifetime, flush, and in-flight accounting.

## Interface
- WIDTH, 512, operand/result width (LANES × 32)
- TAG_WIDTH, 3, FPU tag width; NUM_TAGS = 2^TAG_WIDTH in-flight slots
- META_WIDTH, 10, opaque writeback metadata (warp id, rd)

- clock  in  1  sole clock
- reset  in  1  synchronous, active-low (reset when 0)
- cmd_valid / cmd_ready  in / out  1  upstream command handshake
- cmd_bits_operands_{0,1,2}  in  WIDTH  source operands
- cmd_bits_op  in  5  {op_mod, op[3:0]}
- cmd_bits_roundingMode  in  3
- cmd_bits_srcFormat, cmd_bits_dstFormat  in  3 each
- cmd_bits_intFormat  in  2
- cmd_bits_simdMask  in  16  lane mask
- cmd_bits_meta  in  META_WIDTH  stored per tag
- fpu_req_valid / fpu_req_ready  out / in  1  FPU request handshake
- fpu_req_bits_*  out  same widths as cmd_bits_* (minus meta), plus fpu_req_bits_tag TAG_WIDTH
- fpu_resp_valid / fpu_resp_ready  in / out  1
- fpu_resp_bits_result  in  WIDTH; fpu_resp_bits_status  in  5; fpu_resp_bits_tag  in  TAG_WIDTH
- fpu_flush  out  1  flush to FPU
- abort  in  1  squash all in-flight work
- wb_valid / wb_ready  out / in  1  writeback handshake
- wb_bits_result  out  WIDTH; wb_bits_status  out  5; wb_bits_meta  out  META_WIDTH
- inflight_count  out  TAG_WIDTH+1  allocated tags
- spurious_err  out  1  sticky: response tag not allocated
- busy  out  1  any tag allocated, req register valid, or wb register valid
- fflags  out  5  accumulated status (see Configuration)
- fflags_clear  in  1

## Operation
- Tag table: NUM_TAGS entries {alloc bit, meta}. Allocation picks lowest-index free tag.
- cmd_ready = !abort && free tag exists && (!fpu_req_valid || fpu_req_ready).
- Command fire: capture fields into request register, set fpu_req_valid, set alloc[tag], store meta. Request register holds until fpu_req_ready.
- fpu_resp_ready = !abort && (!wb_valid || wb_ready).
- Response fire: if alloc[tag]: load wb register {result, status, meta[tag]}, clear alloc[tag]. Else drop, set spurious_err (cleared only by reset).
- Same-cycle free and allocate: freed tag becomes allocatable next cycle only; inflight_count applies +1 and −1 in the same cycle (net 0).
- abort: in that cycle fpu_flush=1, all alloc bits cleared, fpu_req_valid and wb_valid cleared next cycle, no cmd/resp accepted. Responses arriving after abort hit unallocated tags → dropped, spurious_err set (FPU flush makes this a bug indicator).
- Full: inflight_count = NUM_TAGS → cmd_ready=0.

## Timing
- Reset values: cmd_ready 0 in reset cycle, fpu_req_valid 0, fpu_resp_ready 0 in reset, wb_valid 0, fpu_flush 0, inflight_count 0, spurious_err 0, busy 0, fflags 0, all alloc bits 0.
- Command accepted at N → fpu_req_valid at N+1.
- Response accepted at M → wb_valid at M+1; back-to-back responses sustain 1/cycle when wb_ready=1.
- fpu_flush is combinational from abort (same cycle), one cycle per abort cycle.
- valid signals never drop without corresponding ready, except on abort/reset.

## Configuration
- FPU_ISSUER_FFLAGS_EN defined: fflags register ORs wb_bits_status on each wb fire; fflags_clear zeroes it (clear wins over same-cycle OR).
- Undefined: fflags tied to 0, fflags_clear ignored, no register.

## Test plan
- Single op: cmd meta=0x05 at cycle 1 → fpu_req_valid cycle 2 tag 0; resp tag 0 result 0xA… → wb_valid next cycle, wb_bits_meta=0x05, inflight_count 1→0.
- Fill: 8 commands with fpu_req_ready=1, no responses → tags 0..7, inflight_count=8, cmd_ready=0; return tag 3 → next command gets tag 3.
- Out-of-order: issue tags 0,1,2 metas 0x10,0x11,0x12; respond 2,0,1 → wb metas 0x12,0x10,0x11 in order.
- Backpressure: wb_ready=0 with one wb pending → fpu_resp_ready=0, no response lost; release → both delivered.
- Abort with 4 in flight: fpu_flush=1 that cycle, inflight_count=0 next cycle, busy=0; later resp tag 1 → dropped, spurious_err=1.
- FFLAGS_EN: statuses 0x01 then 0x10 → fflags=0x11; fflags_clear → 0x00.
